alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational 6-bit ALU between NUM_REQ requesters.
- Sits between the requesting controllers (FSM-controller class blocks) and the ALU.
- Arbitrates round-robin, drives the ALU operand/op bus, and returns the result and flags to the granted requester.
- Runs one operation at a time through a small issue/execute/respond state machine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 6, operand/result width.
- ALU_LAT, 1, number of cycles a/b/op are held before result/flags are sampled (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_a  input  NUM_REQ*WIDTH  flattened operand A; slice i = [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened operand B, same slicing.
- req_op  input  NUM_REQ*2  flattened opcode; slice i = [i*2 +: 2].
- req_ready  output  NUM_REQ  one-hot grant; a transfer happens when valid & ready.
- a  output  WIDTH  operand A to ALU.
- b  output  WIDTH  operand B to ALU.
- op  output  2  opcode to ALU.
- result  input  WIDTH  ALU result.
- gt_zero_flag  input  1  ALU flag: result nonzero.
- SF  input  1  ALU sign flag.
- CF  input  1  ALU carry flag.
- ZF  input  1  ALU zero flag.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_result  output  WIDTH  captured result, shared by all requesters.
- rsp_flags  output  4  captured flags {gt_zero_flag, SF, CF, ZF}.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, wait counter=0, grant id=0. Outputs a, b, op, rsp_result, rsp_flags, rsp_valid and busy are all 0.
- Reset is synchronous and has priority. Asserted mid-operation, it drops the in-flight op: no rsp_valid is ever produced for it, and state returns to IDLE on the next edge.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and one-hot, asserted only in IDLE.
  - Winner g = first set req_valid bit searching upward from rr_ptr, with wrap-around. No valid requests means req_ready=0.
  - On a grant edge: a/b/op <= slice g, gid <= g, rr_ptr <= (g+1) mod NUM_REQ, wait counter <= ALU_LAT-1, state -> EXEC.
- EXEC:
  - a/b/op held stable.
  - Counter decrements each cycle. When it reads 0: rsp_result <= result, rsp_flags <= {gt_zero_flag, SF, CF, ZF}, state -> RESP.
  - EXEC lasts exactly ALU_LAT cycles.
- RESP:
  - rsp_valid[gid]=1 for exactly one cycle; rsp_result and rsp_flags valid in that cycle; state -> IDLE.
- Timing: grant at cycle T; rsp_valid at cycle T+ALU_LAT+1; next grant earliest at T+ALU_LAT+2.
- Throughput: one op per ALU_LAT+2 cycles.
- a/b/op and rsp_result/rsp_flags hold their last values until overwritten. rsp_valid=0 outside RESP.
- Requesters hold req_valid and operands stable until the ready handshake. Dropping req_valid before grant is legal; that request is simply not granted.
- req_valid changes during EXEC/RESP are ignored. Arbitration samples only in IDLE.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- rr_ptr advances only on a grant.
- busy=0 in IDLE even while req_ready is asserted.

Test Plan:
- Reset with ALU_LAT=1, all req_valid=0 -> all outputs 0, busy=0, req_ready=0, state IDLE held.
- Single request: req0 a=110011, b=101010, op=00 at T, with the ALU model returning result=111011, SF=1, CF=0, ZF=0, gt=1.
  - T: req_ready=0001.
  - T+1: a=110011, b=101010, op=00.
  - T+2: rsp_valid=0001, rsp_result=111011, rsp_flags=1100.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0 with grants spaced 3 cycles apart. Each rsp_valid bit matches the prior grant.
- rr_ptr wrap: after req3 granted, assert req1 and req3 -> req1 granted first, then req3.
- ALU_LAT=3 build, req2 op=01 a=110011 b=000001 -> a/b/op stable for 3 cycles; rsp_valid=0100 at T+4 with result=111001, and flags taken from the final EXEC cycle.
- Reset asserted in EXEC cycle of a req1 op -> no rsp_valid ever for it; next edge all outputs 0, rr_ptr=0; a subsequent req1 request is granted normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among requesters
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 6,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b,
  output logic [1:0]               op,
  input  logic [WIDTH-1:0]         result,
  input  logic                     gt_zero_flag,
  input  logic                     SF,
  input  logic                     CF,
  input  logic                     ZF,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [3:0]               rsp_flags,
  output logic                     busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, gid, win, idx;
  logic [CW-1:0] cnt;
  logic found;
  // winner: first valid requester at or above rr_ptr, wrapping around
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // next state and strobes; grants only ever leave IDLE
  always_comb begin
    state_nx = state == IDLE ? (found ? EXEC : IDLE) :
               state == EXEC ? (cnt == '0 ? RESP : EXEC) : IDLE;
    req_ready = state == IDLE && found ? NUM_REQ'(1) << win : '0;
    rsp_valid = state == RESP ? NUM_REQ'(1) << gid : '0;
    busy = state != IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // operand latch on grant, countdown in EXEC, capture on the last EXEC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      op <= '0;
      rr_ptr <= '0;
      gid <= '0;
      cnt <= '0;
      rsp_result <= '0;
      rsp_flags <= '0;
    end else if (state == IDLE && found) begin
      a <= req_a[int'(win)*WIDTH +: WIDTH];
      b <= req_b[int'(win)*WIDTH +: WIDTH];
      op <= req_op[int'(win)*2 +: 2];
      gid <= win;
      rr_ptr <= PW'((int'(win) + 1) % NUM_REQ);
      cnt <= CW'(ALU_LAT - 1);
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        rsp_result <= result;
        rsp_flags <= {gt_zero_flag, SF, CF, ZF};
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed checks of the shared-ALU arbiter
module tb_alu_share_arbiter;
  logic clk = 0;
  logic reset = 0;
  logic [3:0] req_valid = '0;
  logic [23:0] req_a = '0, req_b = '0;
  logic [7:0] req_op = '0;
  logic [9:0] noise3 = '0;
  logic [3:0] ready1, rv1, rf1, ready3, rv3, rf3;
  logic [5:0] a1, b1, rr1, res1, a3, b3, rr3, res3;
  logic [1:0] op1, op3;
  logic gt1, sf1, cf1, zf1, busy1, gt3, sf3, cf3, zf3, busy3;
  int vectors = 0, miscompares = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: {gt, SF, CF, ZF, result}
  function automatic logic [9:0] alu(input logic [5:0] x, input logic [5:0] y, input logic [1:0] o);
    logic [5:0] r;
    logic c;
    c = 1'b0;
    case (o)
      2'b00: r = x | y;
      2'b01: r = $signed(x) >>> y[2:0];
      2'b10: {c, r} = {1'b0, x} + {1'b0, y};
      default: {c, r} = {1'b0, x} - {1'b0, y};
    endcase
    return {r != 0, r[5], c, r == 0, r};
  endfunction

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  assign {gt1, sf1, cf1, zf1, res1} = alu(a1, b1, op1);
  assign {gt3, sf3, cf3, zf3, res3} = alu(a3, b3, op3) ^ noise3;

  alu_share_arbiter #(.NUM_REQ(4), .WIDTH(6), .ALU_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(ready1), .a(a1), .b(b1), .op(op1), .result(res1),
    .gt_zero_flag(gt1), .SF(sf1), .CF(cf1), .ZF(zf1), .rsp_valid(rv1),
    .rsp_result(rr1), .rsp_flags(rf1), .busy(busy1));

  alu_share_arbiter #(.NUM_REQ(4), .WIDTH(6), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(ready3), .a(a3), .b(b3), .op(op3), .result(res3),
    .gt_zero_flag(gt3), .SF(sf3), .CF(cf3), .ZF(zf3), .rsp_valid(rv3),
    .rsp_result(rr3), .rsp_flags(rf3), .busy(busy3));

  task automatic apply_reset;
    @(negedge clk);
    reset = 1;
    req_valid = '0;
    noise3 = '0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic set_req(input int i, input logic [5:0] x, input logic [5:0] y, input logic [1:0] o);
    req_a[i*6 +: 6] = x;
    req_b[i*6 +: 6] = y;
    req_op[i*2 +: 2] = o;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({a1, b1, op1, rr1, rf1, rv1, busy1, ready1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", {a1, b1, op1, rr1, rf1, rv1, busy1, ready1});
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({busy1, ready1, rv1} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle_hold cycle %0d: got %h required 0", i, {busy1, ready1, rv1});
      end
    end
  endtask

  task automatic test_single;
    apply_reset();
    set_req(0, 6'b110011, 6'b101010, 2'b00);
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (ready1 !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b required 0001", ready1); end
    vectors++;
    if (busy1 !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle: got %b required 0", busy1); end
    @(negedge clk);
    req_valid = '0;
    #1;
    vectors++;
    if ({a1, b1, op1} !== {6'b110011, 6'b101010, 2'b00}) begin
      miscompares++;
      $display("FAIL single_operands: got %b %b %b required 110011 101010 00", a1, b1, op1);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({rv1, rr1, rf1} !== {4'b0001, 6'b111011, 4'b1100}) begin
      miscompares++;
      $display("FAIL single_response: got %b %b %b required 0001 111011 1100", rv1, rr1, rf1);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({rv1, busy1} !== 5'b0) begin miscompares++; $display("FAIL single_after: got %b required 0", {rv1, busy1}); end
  endtask

  task automatic test_all_valid;
    int last;
    logic [9:0] e;
    apply_reset();
    req_a = 24'($urandom());
    req_b = 24'($urandom());
    req_op = 8'($urandom());
    req_valid = 4'hF;
    last = 0;
    #1;
    for (int n = 0; n < 5; n++) begin
      int t = 0;
      while (ready1 == '0 && t < 10) begin
        @(negedge clk);
        #1;
        t++;
      end
      vectors++;
      if (ready1 !== 4'(1 << (n % 4))) begin
        miscompares++;
        $display("FAIL rr_order grant %0d: got %b required %b", n, ready1, 4'(1 << (n % 4)));
      end
      if (n > 0) begin
        vectors++;
        if (cyc - last !== 3) begin miscompares++; $display("FAIL rr_spacing grant %0d: got %0d required 3", n, cyc - last); end
      end
      last = cyc;
      e = alu(req_a[(n % 4)*6 +: 6], req_b[(n % 4)*6 +: 6], req_op[(n % 4)*2 +: 2]);
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if ({rv1, rr1, rf1} !== {4'(1 << (n % 4)), e[5:0], e[9:6]}) begin
        miscompares++;
        $display("FAIL rr_response grant %0d: got %b %b %b required %b %b %b", n, rv1, rr1, rf1, 4'(1 << (n % 4)), e[5:0], e[9:6]);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_wrap;
    req_valid = 4'b1000;
    #1;
    vectors++;
    if (ready1 !== 4'b1000) begin miscompares++; $display("FAIL wrap_req3: got %b required 1000", ready1); end
    @(negedge clk);
    req_valid = 4'b1010;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (ready1 !== 4'b0010) begin miscompares++; $display("FAIL wrap_req1_first: got %b required 0010", ready1); end
    @(negedge clk);
    req_valid = 4'b1000;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (ready1 !== 4'b1000) begin miscompares++; $display("FAIL wrap_req3_next: got %b required 1000", ready1); end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    int mptr, g;
    logic [3:0] er;
    logic [5:0] ea, eb;
    logic [1:0] eo;
    logic [9:0] e;
    apply_reset();
    mptr = 0;
    for (int it = 0; it < 40; it++) begin
      req_a = 24'($urandom());
      req_b = 24'($urandom());
      req_op = 8'($urandom());
      req_valid = 4'($urandom_range(0, 15));
      #1;
      g = pick(req_valid, mptr);
      er = g < 0 ? 4'b0 : 4'(1 << g);
      vectors++;
      if ({ready1, busy1} !== {er, 1'b0}) begin
        miscompares++;
        $display("FAIL rand_grant it %0d: got %b/%b required %b/0", it, ready1, busy1, er);
      end
      if (g >= 0) begin
        mptr = (g + 1) % 4;
        ea = req_a[g*6 +: 6];
        eb = req_b[g*6 +: 6];
        eo = req_op[g*2 +: 2];
        e = alu(ea, eb, eo);
        @(negedge clk);
        req_valid = 4'($urandom());
        req_a = 24'($urandom());
        #1;
        vectors++;
        if ({a1, b1, op1, busy1, ready1} !== {ea, eb, eo, 1'b1, 4'b0}) begin
          miscompares++;
          $display("FAIL rand_exec it %0d: got %h required %h", it, {a1, b1, op1, busy1, ready1}, {ea, eb, eo, 1'b1, 4'b0});
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({rv1, rr1, rf1} !== {er, e[5:0], e[9:6]}) begin
          miscompares++;
          $display("FAIL rand_resp it %0d: got %b %b %b required %b %b %b", it, rv1, rr1, rf1, er, e[5:0], e[9:6]);
        end
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_mid_reset;
    logic [9:0] e;
    apply_reset();
    set_req(1, 6'b010101, 6'b001100, 2'b10);
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (ready1 !== 4'b0010) begin miscompares++; $display("FAIL midrst_grant: got %b required 0010", ready1); end
    @(negedge clk);
    reset = 1;
    req_valid = '0;
    @(negedge clk);
    #1;
    vectors++;
    if ({a1, b1, op1, rr1, rf1, rv1, busy1, ready1} !== '0) begin
      miscompares++;
      $display("FAIL midrst_clear: got %h required 0", {a1, b1, op1, rr1, rf1, rv1, busy1, ready1});
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (rv1 !== 4'b0) begin miscompares++; $display("FAIL midrst_no_rsp cycle %0d: got %b required 0000", i, rv1); end
    end
    set_req(1, 6'b110000, 6'b010001, 2'b11);
    e = alu(6'b110000, 6'b010001, 2'b11);
    req_valid = 4'b1010;
    #1;
    vectors++;
    if (ready1 !== 4'b0010) begin miscompares++; $display("FAIL midrst_ptr_zero: got %b required 0010", ready1); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    vectors++;
    if ({rv1, rr1, rf1} !== {4'b0010, e[5:0], e[9:6]}) begin
      miscompares++;
      $display("FAIL midrst_regrant: got %b %b %b required 0010 %b %b", rv1, rr1, rf1, e[5:0], e[9:6]);
    end
    @(negedge clk);
  endtask

  task automatic test_lat3;
    apply_reset();
    set_req(2, 6'b110011, 6'b000001, 2'b01);
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (ready3 !== 4'b0100) begin miscompares++; $display("FAIL lat3_grant: got %b required 0100", ready3); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      req_valid = '0;
      noise3 = i < 3 ? 10'h3FF : 10'h0;
      #1;
      vectors++;
      if ({a3, b3, op3, rv3, busy3} !== {6'b110011, 6'b000001, 2'b01, 4'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL lat3_exec cycle %0d: got %b %b %b %b %b required 110011 000001 01 0000 1", i, a3, b3, op3, rv3, busy3);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({rv3, rr3, rf3} !== {4'b0100, 6'b111001, 4'b1100}) begin
      miscompares++;
      $display("FAIL lat3_resp: got %b %b %b required 0100 111001 1100", rv3, rr3, rf3);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({rv3, busy3} !== 5'b0) begin miscompares++; $display("FAIL lat3_after: got %b required 0", {rv3, busy3}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_random();
    test_mid_reset();
    test_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
